// File: rtl/nibble_serial_subtractor_if.sv
// Operand/result handshake bundle for the nibble-serial subtractor.
// Master drives operands and accepts results; slave is the subtractor.
interface nibble_serial_subtractor_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;
    logic             ovf;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, zero, ovf
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, zero, ovf
    );
endinterface

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, one 4-bit borrow slice
// reused LSB-first across WIDTH/4 clock edges.
module nibble_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input logic clk,
    input logic rst,
    nibble_serial_subtractor_if.slave io
);
    localparam int N  = WIDTH / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, b_q, diff_q, diff_nx;
    logic [CW-1:0]    cnt;
    logic             borrow;
    logic             bout_q, zero_q, ovf_q;
    logic             load, step, last;
    logic [3:0]       a_nib, b_nib;
    logic [4:0]       t;

    assign last = (cnt == LAST);

    // Single shared slice, operand nibbles selected by the step counter
    always_comb begin
        a_nib = a_q[{cnt, 2'b00} +: 4];
        b_nib = b_q[{cnt, 2'b00} +: 4];
        t = {1'b0, a_nib} - {1'b0, b_nib} - {4'b0000, borrow};
        diff_nx = diff_q;
        diff_nx[{cnt, 2'b00} +: 4] = t[3:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (io.in_valid) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                if (io.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (load) begin
                a_q    <= io.a;
                b_q    <= io.b;
                borrow <= io.bin;
                cnt    <= '0;
            end
            if (step) begin
                diff_q <= diff_nx;
                borrow <= t[4];
                cnt    <= cnt + 1'b1;
                if (last) begin
                    bout_q <= t[4];
                    zero_q <= (diff_nx == '0);
                    ovf_q  <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                              (diff_nx[WIDTH-1] != a_q[WIDTH-1]);
                end
            end
        end
    end

    assign io.in_ready  = (state_q == IDLE);
    assign io.out_valid = (state_q == DONE);
    assign io.diff      = diff_q;
    assign io.bout      = bout_q;
    assign io.zero      = zero_q;
    assign io.ovf       = ovf_q;
endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed and randomized checks for nibble_serial_subtractor (WIDTH=16).
// Stimulus is driven and sampled 1 time unit after each rising edge.
module tb_nibble_serial_subtractor;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   lat;

    nibble_serial_subtractor_if #(.WIDTH(W)) ifc ();

    nibble_serial_subtractor #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .io  (ifc.slave)
    );

    always #5 clk = ~clk;

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic bin);
        int w;
        w = 0;
        while (!ifc.in_ready && w < 20) begin
            @(posedge clk); #1; w++;
        end
        ifc.a = a; ifc.b = b; ifc.bin = bin; ifc.in_valid = 1'b1;
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        lat = 0;
        while (!ifc.out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic consume();
        ifc.out_ready = 1'b1;
        @(posedge clk); #1;
        ifc.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (ifc.in_ready !== 1'b1 || ifc.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1 0",
                     ifc.in_ready, ifc.out_valid);
        end
        checks++;
        if ({ifc.diff, ifc.bout, ifc.zero, ifc.ovf} !== '0) begin
            errors++;
            $display("FAIL reset_data: diff=%h b/z/o=%b%b%b want 0",
                     ifc.diff, ifc.bout, ifc.zero, ifc.ovf);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] va [5] = '{16'h1234, 16'h0000, 16'h8000,
                                 16'h5555, 16'h0007};
        logic [W-1:0] vb [5] = '{16'h0034, 16'h0001, 16'h0001,
                                 16'h5554, 16'h0007};
        logic vbin [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [W-1:0] ed [5] = '{16'h1200, 16'hFFFF, 16'h7FFF,
                                 16'h0000, 16'hFFFF};
        logic [2:0] ef [5] = '{3'b000, 3'b100, 3'b001,
                               3'b010, 3'b100};
        for (int i = 0; i < 5; i++) begin
            do_op(va[i], vb[i], vbin[i]);
            checks++;
            if (lat !== 4) begin
                errors++;
                $display("FAIL dir%0d_latency: got %0d want 4", i, lat);
            end
            checks++;
            if (ifc.diff !== ed[i]) begin
                errors++;
                $display("FAIL dir%0d_diff: got %h want %h",
                         i, ifc.diff, ed[i]);
            end
            checks++;
            if ({ifc.bout, ifc.zero, ifc.ovf} !== ef[i]) begin
                errors++;
                $display("FAIL dir%0d_flags: bzo got %b want %b", i,
                         {ifc.bout, ifc.zero, ifc.ovf}, ef[i]);
            end
            consume();
        end
    endtask

    task automatic test_backpressure();
        logic [W+2:0] snap;
        do_op(16'hA5A5, 16'h1111, 1'b0);
        snap = {ifc.diff, ifc.bout, ifc.zero, ifc.ovf};
        checks++;
        if (snap !== {16'h9494, 3'b000}) begin
            errors++;
            $display("FAIL bp_result: got %h want %h", snap,
                     {16'h9494, 3'b000});
        end
        ifc.a = 16'h0000; ifc.b = 16'hFFFF; ifc.bin = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ifc.in_valid = (i == 2);
            @(posedge clk); #1;
            checks++;
            if (ifc.out_valid !== 1'b1 || ifc.in_ready !== 1'b0 ||
                {ifc.diff, ifc.bout, ifc.zero, ifc.ovf} !== snap) begin
                errors++;
                $display("FAIL bp_hold%0d: ov=%b ir=%b data=%h want 1 0 %h",
                         i, ifc.out_valid, ifc.in_ready,
                         {ifc.diff, ifc.bout, ifc.zero, ifc.ovf}, snap);
            end
        end
        ifc.in_valid = 1'b0;
        consume();
        checks++;
        if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1 ||
            ifc.diff !== 16'h9494) begin
            errors++;
            $display("FAIL bp_release: ov=%b ir=%b diff=%h want 0 1 9494",
                     ifc.out_valid, ifc.in_ready, ifc.diff);
        end
    endtask

    task automatic test_async_reset();
        ifc.a = 16'h1357; ifc.b = 16'h0246; ifc.bin = 1'b0;
        ifc.in_valid = 1'b1;
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1 ||
            ifc.diff !== '0) begin
            errors++;
            $display("FAIL async_rst: ov=%b ir=%b diff=%h want 0 1 0000",
                     ifc.out_valid, ifc.in_ready, ifc.diff);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        do_op(16'h00FF, 16'h000F, 1'b0);
        checks++;
        if (lat !== 4 || ifc.diff !== 16'h00F0) begin
            errors++;
            $display("FAIL post_rst_op: lat=%0d diff=%h want 4 00f0",
                     lat, ifc.diff);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ra, rb, ediff;
        logic         rbin, eb, ez, eo;
        logic [W:0]   full;
        int           stall;
        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rbin = 1'($urandom);
            if (i % 8 == 0) rb = ra;
            full = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
            ediff = full[W-1:0];
            eb = full[W];
            ez = (ediff == '0);
            eo = (ra[W-1] ^ rb[W-1]) & (ediff[W-1] ^ ra[W-1]);
            do_op(ra, rb, rbin);
            checks++;
            if (lat !== 4 || ifc.diff !== ediff ||
                {ifc.bout, ifc.zero, ifc.ovf} !== {eb, ez, eo}) begin
                errors++;
                $display("FAIL rnd%0d: %h-%h-%b got lat=%0d %h bzo=%b want %h bzo=%b",
                         i, ra, rb, rbin, lat, ifc.diff,
                         {ifc.bout, ifc.zero, ifc.ovf}, ediff, {eb, ez, eo});
            end
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) begin
                @(posedge clk); #1;
            end
            consume();
        end
    endtask

    initial begin
        ifc.in_valid = 1'b0;
        ifc.out_ready = 1'b0;
        ifc.a = '0;
        ifc.b = '0;
        ifc.bin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
